// File: rtl/skin_bbox_detect.sv
// skin_bbox_detect: per-frame bounding box and hit count of skin-mask pixels, published on vsync rise
module skin_bbox_detect #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int MIN_PIXELS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_bit,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [9:0]  box_y_min,
  output logic [9:0]  box_y_max,
  output logic [18:0] box_pix_cnt,
  output logic        box_valid,
  output logic        frame_done
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_ACTIVE = 1'b1;
  localparam logic [10:0] H_LIM = IMG_H_DISP[10:0];
  localparam logic [10:0] V_LIM = IMG_V_DISP[10:0];
  localparam logic [19:0] MIN_LIM = MIN_PIXELS[19:0];
  logic state_q, state_d, vsync_q, href_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [18:0] cnt_q, cnt_d;
  logic [9:0] bx_xmin_q, bx_xmin_d, bx_xmax_q, bx_xmax_d, bx_ymin_q, bx_ymin_d, bx_ymax_q, bx_ymax_d;
  logic [18:0] bx_cnt_q, bx_cnt_d;
  logic valid_q, valid_d, done_q, done_d;
  logic vs_rise, hr_fall, pix, hit, publish, ok;
  always_comb begin
    vs_rise = per_frame_vsync & ~vsync_q;
    hr_fall = ~per_frame_href & href_q;
    pix = per_frame_href & per_frame_clken;
    // a sample landing on the frame boundary belongs to neither frame
    hit = (state_q == S_ACTIVE) & pix & per_img_bit & ({1'b0, x_q} < H_LIM) & ({1'b0, y_q} < V_LIM) & ~vs_rise;
    publish = vs_rise & (state_q == S_ACTIVE);
    ok = {1'b0, cnt_q} >= MIN_LIM;
    state_d = vs_rise ? S_ACTIVE : state_q;
    x_d = (vs_rise | hr_fall) ? '0 : (pix & (x_q != '1)) ? x_q + 10'd1 : x_q;
    y_d = vs_rise ? '0 : (hr_fall & (y_q != '1)) ? y_q + 10'd1 : y_q;
    xmin_d = vs_rise ? '1 : (hit & (x_q < xmin_q)) ? x_q : xmin_q;
    xmax_d = vs_rise ? '0 : (hit & (x_q > xmax_q)) ? x_q : xmax_q;
    ymin_d = vs_rise ? '1 : (hit & (y_q < ymin_q)) ? y_q : ymin_q;
    ymax_d = vs_rise ? '0 : (hit & (y_q > ymax_q)) ? y_q : ymax_q;
    cnt_d = vs_rise ? '0 : (hit & (cnt_q != '1)) ? cnt_q + 19'd1 : cnt_q;
    bx_xmin_d = publish ? (ok ? xmin_q : '0) : bx_xmin_q;
    bx_xmax_d = publish ? (ok ? xmax_q : '0) : bx_xmax_q;
    bx_ymin_d = publish ? (ok ? ymin_q : '0) : bx_ymin_q;
    bx_ymax_d = publish ? (ok ? ymax_q : '0) : bx_ymax_q;
    bx_cnt_d = publish ? cnt_q : bx_cnt_q;
    valid_d = publish ? ok : valid_q;
    done_d = publish;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      xmin_q <= '1;
      xmax_q <= '0;
      ymin_q <= '1;
      ymax_q <= '0;
      cnt_q <= '0;
      bx_xmin_q <= '0;
      bx_xmax_q <= '0;
      bx_ymin_q <= '0;
      bx_ymax_q <= '0;
      bx_cnt_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= per_frame_vsync;
      href_q <= per_frame_href;
      x_q <= x_d;
      y_q <= y_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q <= cnt_d;
      bx_xmin_q <= bx_xmin_d;
      bx_xmax_q <= bx_xmax_d;
      bx_ymin_q <= bx_ymin_d;
      bx_ymax_q <= bx_ymax_d;
      bx_cnt_q <= bx_cnt_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  assign box_x_min = bx_xmin_q;
  assign box_x_max = bx_xmax_q;
  assign box_y_min = bx_ymin_q;
  assign box_y_max = bx_ymax_q;
  assign box_pix_cnt = bx_cnt_q;
  assign box_valid = valid_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_skin_bbox_detect.sv
// tb_skin_bbox_detect: directed checks of skin_bbox_detect with a 16x8 image
module tb_skin_bbox_detect;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0, clken = 1'b0, bitv = 1'b0;
  logic [9:0] a_xmin, a_xmax, a_ymin, a_ymax, b_xmin, b_xmax, b_ymin, b_ymax;
  logic [18:0] a_cnt, b_cnt;
  logic a_valid, a_done, b_valid, b_done;
  int n_chk = 0, n_fail = 0, fd_cnt = 0;
  always #5 clk = ~clk;
  skin_bbox_detect #(.IMG_H_DISP(16), .IMG_V_DISP(8), .MIN_PIXELS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(bitv), .box_x_min(a_xmin), .box_x_max(a_xmax),
    .box_y_min(a_ymin), .box_y_max(a_ymax), .box_pix_cnt(a_cnt), .box_valid(a_valid),
    .frame_done(a_done));
  skin_bbox_detect #(.IMG_H_DISP(16), .IMG_V_DISP(8), .MIN_PIXELS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_bit(bitv), .box_x_min(b_xmin), .box_x_max(b_xmax),
    .box_y_min(b_ymin), .box_y_max(b_ymax), .box_pix_cnt(b_cnt), .box_valid(b_valid),
    .frame_done(b_done));
  always @(posedge clk) if (a_done) fd_cnt <= fd_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic line(input logic [31:0] m, input int n);
    href = 1'b1;
    for (int c = 0; c < n; c++) begin
      clken = 1'b1;
      bitv = m[c];
      tick();
    end
    clken = 1'b0;
    bitv = 1'b0;
    href = 1'b0;
    tick();
    tick();
  endtask
  task automatic vs_pulse(input logic exp_done);
    vsync = 1'b1;
    tick();
    chk("frame_done_latency", {31'd0, a_done}, {31'd0, exp_done});
    vsync = 1'b0;
    tick();
    tick();
  endtask
  task automatic chk_a(input string tag, input int xl, input int xh, input int yl, input int yh, input int cnt, input int v);
    chk({tag, "_a_xmin"}, {22'd0, a_xmin}, xl);
    chk({tag, "_a_xmax"}, {22'd0, a_xmax}, xh);
    chk({tag, "_a_ymin"}, {22'd0, a_ymin}, yl);
    chk({tag, "_a_ymax"}, {22'd0, a_ymax}, yh);
    chk({tag, "_a_cnt"}, {13'd0, a_cnt}, cnt);
    chk({tag, "_a_valid"}, {31'd0, a_valid}, v);
  endtask
  initial begin
    tick();
    tick();
    chk_a("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_done", {31'd0, a_done}, 0);
    rst_n = 1'b1;
    tick();
    vs_pulse(1'b0);
    chk("t1_no_first_done", fd_cnt, 0);
    for (int r = 0; r < 8; r++) line(32'h0, 16);
    vs_pulse(1'b1);
    chk("t1_fd_cnt", fd_cnt, 1);
    chk_a("t1", 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 8; r++) line((r >= 2 && r <= 4) ? 32'h78 : 32'h0, 16);
    vs_pulse(1'b1);
    chk("t2_fd_cnt", fd_cnt, 2);
    chk_a("t2", 3, 6, 2, 4, 12, 1);
    for (int r = 0; r < 8; r++) line(r == 1 ? 32'h220 : (r == 7 ? 32'h1 : 32'h0), 16);
    vs_pulse(1'b1);
    chk_a("t3", 0, 0, 0, 0, 3, 0);
    chk("t3_b_xmin", {22'd0, b_xmin}, 0);
    chk("t3_b_xmax", {22'd0, b_xmax}, 9);
    chk("t3_b_ymin", {22'd0, b_ymin}, 1);
    chk("t3_b_ymax", {22'd0, b_ymax}, 7);
    chk("t3_b_cnt", {13'd0, b_cnt}, 3);
    chk("t3_b_valid", {31'd0, b_valid}, 1);
    line(32'h1F0000, 21);
    for (int r = 1; r < 8; r++) line(32'h0, 16);
    line(32'hFFFF, 16);
    vs_pulse(1'b1);
    chk_a("t4", 0, 0, 0, 0, 0, 0);
    chk("t4_fd_cnt", fd_cnt, 4);
    line(32'hF, 16);
    href = 1'b1;
    clken = 1'b1;
    bitv = 1'b1;
    vsync = 1'b1;
    tick();
    chk("t5_done", {31'd0, a_done}, 1);
    chk_a("t5_old", 0, 3, 0, 0, 4, 1);
    vsync = 1'b0;
    clken = 1'b0;
    bitv = 1'b0;
    href = 1'b0;
    tick();
    tick();
    line(32'hF0, 16);
    vs_pulse(1'b1);
    chk_a("t5_new", 4, 7, 1, 1, 4, 1);
    chk("t5_fd_cnt", fd_cnt, 6);
    line(32'h3FF, 16);
    rst_n = 1'b0;
    #1;
    chk_a("t6_rst", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    vs_pulse(1'b0);
    chk("t6_no_done", fd_cnt, 6);
    line(32'h1F, 16);
    vs_pulse(1'b1);
    chk_a("t6", 0, 4, 0, 0, 5, 1);
    chk("t6_fd_cnt", fd_cnt, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
